// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: pipelined carry-select adder/subtractor.
//
// One SEG-bit segment is resolved per pipeline stage, so there are
// NSEG = WIDTH/SEG stages and a fixed latency of NSEG cycles. Each later stage
// forms both candidate sums for its segment and picks one with the carry
// registered by the previous stage. A single global enable (in_ready) advances
// or holds the whole pipeline; bubbles are kept, not compressed.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of SEG
//   SEG    segment width, SEG >= 2
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   a, b, cin, sub      operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
//   sat, sat_hit        only with CSEL_ADDER_SAT_EN: saturate on overflow
//
// Build option: define CSEL_ADDER_SAT_EN to add signed saturation. cout and
// ovf always report the raw, unsaturated result.

module csel_adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CSEL_ADDER_SAT_EN
  input  logic             sat,
  output logic             sat_hit,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG;
  localparam int unsigned SW   = SEG + 1;

  // Per-stage registers: resolved low segments, operands (b already
  // conditioned for subtract), and carry out of the newest resolved segment.
  logic             vld_q [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic [WIDTH-1:0] opa_q [NSEG];
  logic [WIDTH-1:0] opb_q [NSEG];
  logic             cy_q  [NSEG];
  logic             ovf_q;

  logic [WIDTH-1:0] nxt_res [NSEG];
  logic [WIDTH-1:0] nxt_a   [NSEG];
  logic [WIDTH-1:0] nxt_b   [NSEG];
  logic             nxt_cy  [NSEG];
  logic             nxt_ovf;

`ifdef CSEL_ADDER_SAT_EN
  logic sat_q     [NSEG];
  logic nxt_sat   [NSEG];
  logic sat_hit_q;
  logic nxt_sat_hit;
`endif

  logic             en;
  logic [WIDTH-1:0] src_res;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             src_c;
  logic [SW-1:0]    cand0;
  logic [SW-1:0]    cand1;
  logic [SW-1:0]    pick;
  logic             msb_cin;
  logic             raw_msb;
`ifdef CSEL_ADDER_SAT_EN
  logic             src_sat;
`endif

  // Global enable: the pipeline moves unless a result is stuck at the output.
  assign en       = !vld_q[NSEG-1] || out_ready;
  assign in_ready = en;

  // Next-state for every stage: stage 0 takes the inputs, stage i resolves
  // segment i from stage i-1 by carry-select.
  always_comb begin
    src_res = '0;
    src_a   = '0;
    src_b   = '0;
    src_c   = 1'b0;
    cand0   = '0;
    cand1   = '0;
    pick    = '0;
    msb_cin = 1'b0;
    raw_msb = 1'b0;
    nxt_ovf = 1'b0;
`ifdef CSEL_ADDER_SAT_EN
    src_sat     = 1'b0;
    nxt_sat_hit = 1'b0;
`endif
    for (int i = 0; i < int'(NSEG); i++) begin
      nxt_res[i] = '0;
      nxt_a[i]   = '0;
      nxt_b[i]   = '0;
      nxt_cy[i]  = 1'b0;
`ifdef CSEL_ADDER_SAT_EN
      nxt_sat[i] = 1'b0;
`endif
    end

    for (int i = 0; i < int'(NSEG); i++) begin
      if (i == 0) begin
        src_res = '0;
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_c   = sub | cin;
`ifdef CSEL_ADDER_SAT_EN
        src_sat = sat;
`endif
      end else begin
        src_res = res_q[(i == 0) ? 0 : i - 1];
        src_a   = opa_q[(i == 0) ? 0 : i - 1];
        src_b   = opb_q[(i == 0) ? 0 : i - 1];
        src_c   = cy_q[(i == 0) ? 0 : i - 1];
`ifdef CSEL_ADDER_SAT_EN
        src_sat = sat_q[(i == 0) ? 0 : i - 1];
`endif
      end
      cand0 = SW'(src_a[i*SEG +: SEG]) + SW'(src_b[i*SEG +: SEG]);
      cand1 = SW'(src_a[i*SEG +: SEG]) + SW'(src_b[i*SEG +: SEG]) + SW'(1);
      pick  = src_c ? cand1 : cand0;

      nxt_res[i]               = src_res;
      nxt_res[i][i*SEG +: SEG] = pick[SEG-1:0];
      nxt_cy[i]                = pick[SW-1];
      nxt_a[i]                 = src_a;
      nxt_b[i]                 = src_b;
`ifdef CSEL_ADDER_SAT_EN
      nxt_sat[i]               = src_sat;
`endif
    end

    // Carry into the MSB recovered from its sum bit and operand bits.
    raw_msb = nxt_res[NSEG-1][WIDTH-1];
    msb_cin = raw_msb ^ nxt_a[NSEG-1][WIDTH-1] ^ nxt_b[NSEG-1][WIDTH-1];
    nxt_ovf = msb_cin ^ nxt_cy[NSEG-1];

`ifdef CSEL_ADDER_SAT_EN
    // Raw MSB 1 on overflow means positive overflow, 0 means negative.
    if (nxt_sat[NSEG-1] && nxt_ovf) begin
      nxt_res[NSEG-1] = {~raw_msb, {(WIDTH-1){raw_msb}}};
      nxt_sat_hit     = 1'b1;
    end
`endif
  end

  // Pipeline registers, all advanced together by the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NSEG); i++) begin
        vld_q[i] <= 1'b0;
        res_q[i] <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        cy_q[i]  <= 1'b0;
`ifdef CSEL_ADDER_SAT_EN
        sat_q[i] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
`ifdef CSEL_ADDER_SAT_EN
      sat_hit_q <= 1'b0;
`endif
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < int'(NSEG); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      for (int i = 0; i < int'(NSEG); i++) begin
        res_q[i] <= nxt_res[i];
        opa_q[i] <= nxt_a[i];
        opb_q[i] <= nxt_b[i];
        cy_q[i]  <= nxt_cy[i];
`ifdef CSEL_ADDER_SAT_EN
        sat_q[i] <= nxt_sat[i];
`endif
      end
      ovf_q <= nxt_ovf;
`ifdef CSEL_ADDER_SAT_EN
      sat_hit_q <= nxt_sat_hit;
`endif
    end
  end

  assign out_valid = vld_q[NSEG-1];
  assign sum       = res_q[NSEG-1];
  assign cout      = cy_q[NSEG-1];
  assign ovf       = ovf_q;
`ifdef CSEL_ADDER_SAT_EN
  assign sat_hit   = sat_hit_q;
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb_csel_adder_pipe: self-checking bench for csel_adder_pipe (WIDTH=32, SEG=8).
// Directed vector table, reset-flush sequence, randomized stall traffic
// against an arithmetic reference model, and saturation cases when
// CSEL_ADDER_SAT_EN is defined.

module tb_csel_adder_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         sat_drv;
`ifdef CSEL_ADDER_SAT_EN
  logic         sat_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
`ifdef CSEL_ADDER_SAT_EN
    .sat(sat_drv),
    .sat_hit(sat_hit),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 33-bit arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fcin, input logic fsub);
    logic [W-1:0] bx;
    logic [W:0]   t;
    res_t         r;
    bx     = fsub ? ~fb : fb;
    t      = {1'b0, fa} + {1'b0, bx} + (W+1)'(fsub ? 1'b1 : fcin);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (fa[W-1] == bx[W-1]) && (r.sum[W-1] != fa[W-1]);
    return r;
  endfunction

  // Offer one transaction to an idle pipeline and wait for its result.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic ts, output int lat);
    a = ta; b = tb_; cin = tc; sub = ts;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  vec_t vecs [7];
  res_t expq [$];
  res_t er;
  int   lat;
  int   sent;
  int   got;
  logic stalled;
  logic [W-1:0] hold_sum;
  logic hold_cout;
  logic hold_ovf;
  logic seen;

  initial begin
    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_drv = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_sum", sum, '0);
    chk("reset_cout_ovf", W'({cout, ovf}), '0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", W'(in_ready), W'(1));

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      chk($sformatf("vec%0d_latency", i), W'(lat), W'(4));
      chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), W'(cout), W'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), W'(ovf), W'(vecs[i].ovf));
      step();
    end

    // Randomized back-to-back traffic with random output stalls.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      in_valid  = (sent < 16);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      stalled = out_valid && !out_ready;
      chk("rand_in_ready", W'(in_ready), W'(!stalled));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("rand_spurious_result", W'(1), W'(0));
        end else begin
          er = expq.pop_front();
          chk($sformatf("rand%0d_sum", got), sum, er.sum);
          chk($sformatf("rand%0d_flags", got), W'({cout, ovf}), W'({er.cout, er.ovf}));
        end
        got++;
      end
      hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin, sub));
        sent++;
      end
      step();
      if (stalled) begin
        chk("stall_out_valid", W'(out_valid), W'(1));
        chk("stall_sum", sum, hold_sum);
        chk("stall_flags", W'({cout, ovf}), W'({hold_cout, hold_ovf}));
      end
    end
    in_valid = 1'b0;
    chk("rand_results_received", W'(got), W'(16));
    chk("rand_queue_empty", W'(expq.size()), W'(0));

    // Reset with three transactions in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'(i + 100); b = W'(i); cin = 1'b0; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_sum", sum, '0);
    rst = 1'b0;
    #1;
    chk("flush_in_ready", W'(in_ready), W'(1));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_stale_result", W'(seen), '0);
    run_one(32'h00001234, 32'h00004321, 1'b1, 1'b0, lat);
    chk("post_flush_latency", W'(lat), W'(4));
    chk("post_flush_sum", sum, 32'h00005556);
    step();

`ifdef CSEL_ADDER_SAT_EN
    sat_drv = 1'b1;
    run_one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    chk("sat_on_sum", sum, 32'h7FFFFFFF);
    chk("sat_on_hit", W'(sat_hit), W'(1));
    chk("sat_on_ovf", W'(ovf), W'(1));
    chk("sat_on_latency", W'(lat), W'(4));
    step();
    run_one(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
    chk("sat_neg_sum", sum, 32'h80000000);
    chk("sat_neg_hit", W'(sat_hit), W'(1));
    step();
    sat_drv = 1'b0;
    run_one(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
    chk("sat_off_sum", sum, 32'h80000000);
    chk("sat_off_hit", W'(sat_hit), '0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
